// File: rtl/turn_score_ctrl.sv
// turn_score_ctrl
//   Game-state stage that feeds the lower-display player-count mux. It tracks
//   which player holds the turn, the progress count of each of 2-4 players,
//   and reports the winner and end of game.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     start             pulse: begin a new game (ignored while playing)
//     n_sel[1:0]        player-count code sampled on start (11 -> 10)
//     guess_valid       pulse: a tile guess resolved; guess_hit qualifies it
//     T[1:0]            active player index
//     N[1:0]            latched player-count code (00=2, 01=3, 10=4)
//     p1..p4_cnt[4:0]   per-player progress counts
//     game_over         high in DONE
//     winner[1:0]       winning player index, meaningful while game_over=1
//
//   Optional feature macro: TURN_TIMEOUT_EN
//     Enables a 26-bit idle counter in PLAY. It forfeits the turn after
//     TIMEOUT_CYC cycles without a guess.
module turn_score_ctrl #(
  parameter int WIN_CNT     = 24,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] n_sel,
  input  logic       guess_valid,
  input  logic       guess_hit,
  output logic [1:0] T,
  output logic [1:0] N,
  output logic [4:0] p1_cnt,
  output logic [4:0] p2_cnt,
  output logic [4:0] p3_cnt,
  output logic [4:0] p4_cnt,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

  localparam logic [4:0] WIN = 5'(WIN_CNT);

  state_e               state_q, state_d;
  logic [1:0]           t_q, t_d;
  logic [1:0]           n_q, n_d;
  logic [1:0]           win_q, win_d;
  logic [3:0][4:0]      cnt_q, cnt_d;
  logic [1:0]           t_nxt;
  logic                 tmo;

  // The last player index equals the code plus one, so the wrap point
  // follows N directly.
  assign t_nxt = (t_q == n_q + 2'd1) ? 2'd0 : t_q + 2'd1;

`ifdef TURN_TIMEOUT_EN
  localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYC - 1);

  logic [25:0] idle_q, idle_d;

  assign tmo = (state_q == PLAY) && (idle_q == TMO_LAST);

  // Every T change in PLAY comes from a guess or a timeout, so clearing on
  // those two also covers the clear-on-turn-change rule. Outside PLAY the
  // counter sits at 0, so entering PLAY always starts from 0.
  always_comb begin
    idle_d = '0;
    if (state_q == PLAY && !guess_valid && !tmo) idle_d = idle_q + 26'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      PLAY: begin
        // A guess takes priority over a coincident timeout.
        if (guess_valid) begin
          if (guess_hit) begin
            if (cnt_q[t_q] + 5'd1 == WIN) begin
              cnt_d[t_q] = WIN;
              win_d      = t_q;
              state_d    = DONE;
            end else begin
              cnt_d[t_q] = cnt_q[t_q] + 5'd1;
            end
          end else begin
            t_d = t_nxt;
          end
        end else if (tmo) begin
          t_d = t_nxt;
        end
      end
      default: begin  // IDLE and DONE: only start matters
        if (start) begin
          state_d = PLAY;
          n_d     = (n_sel == 2'b11) ? 2'b10 : n_sel;
          t_d     = 2'd0;
          win_d   = 2'd0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      n_q     <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign T         = t_q;
  assign N         = n_q;
  assign winner    = win_q;
  assign game_over = (state_q == DONE);
  assign p1_cnt    = cnt_q[0];
  assign p2_cnt    = cnt_q[1];
  assign p3_cnt    = cnt_q[2];
  assign p4_cnt    = cnt_q[3];

endmodule

// File: tb/tb_turn_score_ctrl.sv
module tb_turn_score_ctrl;

  localparam int WIN     = 4;
  localparam int TMO_CYC = 10;
`ifdef TURN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] n_sel = 2'b00;
  logic       guess_valid = 1'b0;
  logic       guess_hit = 1'b0;
  logic [1:0] T, N, winner;
  logic [4:0] p1_cnt, p2_cnt, p3_cnt, p4_cnt;
  logic       game_over;

  int n_chk  = 0;
  int n_fail = 0;

  turn_score_ctrl #(.WIN_CNT(WIN), .TIMEOUT_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_sel(n_sel),
    .guess_valid(guess_valid), .guess_hit(guess_hit),
    .T(T), .N(N), .p1_cnt(p1_cnt), .p2_cnt(p2_cnt), .p3_cnt(p3_cnt),
    .p4_cnt(p4_cnt), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Observed output word: {T, N, game_over, winner (masked unless game over), p4..p1}
  function automatic logic [26:0] act_word();
    return {T, N, game_over, (game_over ? winner : 2'b00),
            p4_cnt, p3_cnt, p2_cnt, p1_cnt};
  endfunction

  function automatic logic [26:0] mk_word(int t, int n, bit go, int w,
                                          int c0, int c1, int c2, int c3);
    logic [1:0] wm;
    wm = go ? 2'(w) : 2'b00;
    return {2'(t), 2'(n), go, wm, 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (T,N,go,win,p4..p1)", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    bit         st;
    logic [1:0] ns;
    bit         gv;
    bit         gh;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit rst, bit st, int ns, bit gv, bit gh, logic [26:0] exp);
    vec_t v;
    v.rst = rst; v.st = st; v.ns = 2'(ns); v.gv = gv; v.gh = gh; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural reference ----------------
  int  m_phase;      // 0 idle, 1 playing, 2 finished
  int  m_np;         // number of players
  int  m_turn;
  int  m_win;
  int  m_timer;
  int  m_cnt[4];
  int  m_code;

  task automatic m_reset();
    m_phase = 0; m_np = 2; m_turn = 0; m_win = 0; m_timer = 0; m_code = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic m_step(bit st, int ns, bit gv, bit gh);
    bit expired;
    if (m_phase != 1) begin
      if (st) begin
        m_phase = 1;
        m_np    = (ns == 3) ? 4 : ns + 2;
        m_code  = m_np - 2;
        m_turn  = 0; m_win = 0; m_timer = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end
    end else begin
      expired = TMO_EN && (m_timer == TMO_CYC - 1);
      if (gv) begin
        m_timer = 0;
        if (gh) begin
          m_cnt[m_turn]++;
          if (m_cnt[m_turn] == WIN) begin m_phase = 2; m_win = m_turn; end
        end else m_turn = (m_turn + 1) % m_np;
      end else if (expired) begin
        m_turn  = (m_turn + 1) % m_np;
        m_timer = 0;
      end else m_timer++;
    end
  endtask

  function automatic logic [26:0] m_word();
    return mk_word(m_turn, m_code, m_phase == 2, m_win,
                   m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
  endfunction

  task automatic idle_cycles(int n);
    start = 0; guess_valid = 0; guess_hit = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_guess(bit hit);
    guess_valid = 1; guess_hit = hit;
    @(negedge clk);
    guess_valid = 0; guess_hit = 0;
  endtask

  task automatic start_game(int ns);
    start = 1; n_sel = 2'(ns);
    @(negedge clk);
    start = 0;
  endtask

  task automatic sync_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    // 3 players, misses rotate 0->1->2->0
    add(1, 0, 0, 0, 0, mk_word(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, 0, mk_word(0, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 1, 0, mk_word(1, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 1, 0, mk_word(2, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 1, 0, mk_word(0, 1, 0, 0, 0, 0, 0, 0));
    // 2 players: three hits keep the turn, a miss passes it
    add(1, 0, 0, 0, 0, mk_word(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, mk_word(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, 1, mk_word(0, 0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 1, 1, mk_word(0, 0, 0, 0, 2, 0, 0, 0));
    add(0, 0, 0, 1, 1, mk_word(0, 0, 0, 0, 3, 0, 0, 0));
    add(0, 0, 0, 1, 0, mk_word(1, 0, 0, 0, 3, 0, 0, 0));
    // code 11 clamps to 4 players
    add(1, 0, 0, 0, 0, mk_word(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 3, 0, 0, mk_word(0, 2, 0, 0, 0, 0, 0, 0));
    add(0, 0, 3, 1, 0, mk_word(1, 2, 0, 0, 0, 0, 0, 0));
    add(0, 0, 3, 1, 0, mk_word(2, 2, 0, 0, 0, 0, 0, 0));
    add(0, 0, 3, 1, 0, mk_word(3, 2, 0, 0, 0, 0, 0, 0));
    add(0, 0, 3, 1, 0, mk_word(0, 2, 0, 0, 0, 0, 0, 0));
    // player 0 wins with four hits; DONE ignores guesses
    add(1, 0, 0, 0, 0, mk_word(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 2, 0, 0, mk_word(0, 2, 0, 0, 0, 0, 0, 0));
    add(0, 0, 2, 1, 1, mk_word(0, 2, 0, 0, 1, 0, 0, 0));
    add(0, 0, 2, 1, 1, mk_word(0, 2, 0, 0, 2, 0, 0, 0));
    add(0, 0, 2, 1, 1, mk_word(0, 2, 0, 0, 3, 0, 0, 0));
    add(0, 0, 2, 1, 1, mk_word(0, 2, 1, 0, 4, 0, 0, 0));
    add(0, 0, 2, 1, 1, mk_word(0, 2, 1, 0, 4, 0, 0, 0));
    add(0, 0, 2, 1, 0, mk_word(0, 2, 1, 0, 4, 0, 0, 0));
    // start with a guess in DONE: start wins, fresh game
    add(0, 1, 2, 1, 1, mk_word(0, 2, 0, 0, 0, 0, 0, 0));
    // start in PLAY plus a miss: start and new n_sel ignored, miss applied
    add(0, 1, 0, 1, 0, mk_word(1, 2, 0, 0, 0, 0, 0, 0));
    // player 1 wins
    add(0, 0, 0, 1, 1, mk_word(1, 2, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 1, 1, mk_word(1, 2, 0, 0, 0, 2, 0, 0));
    add(0, 0, 0, 1, 1, mk_word(1, 2, 0, 0, 0, 3, 0, 0));
    add(0, 0, 0, 1, 1, mk_word(1, 2, 1, 1, 0, 4, 0, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        start = 0; guess_valid = 0; guess_hit = 0;
        sync_reset();
      end else begin
        start = vecs[i].st; n_sel = vecs[i].ns;
        guess_valid = vecs[i].gv; guess_hit = vecs[i].gh;
        @(negedge clk);
      end
      chk($sformatf("vec%0d", i), act_word(), vecs[i].exp);
    end
    idle_cycles(1);

    // Mid-game async reset for part of a cycle, then guesses are ignored
    sync_reset();
    start_game(2);
    pulse_guess(1);
    pulse_guess(0);
    chk("pre_rst", act_word(), mk_word(1, 2, 0, 0, 1, 0, 0, 0));
    rst_n = 0;
    #2;
    chk("async_rst", act_word(), mk_word(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1;
    #1;
    pulse_guess(1);
    pulse_guess(0);
    pulse_guess(1);
    chk("idle_ignores_guess", act_word(), mk_word(0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized play against the reference model
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        rst_n = 0;
        m_reset();
        #2;
        chk("rand_rst", act_word(), m_word());
        rst_n = 1;
      end
      start       = ($urandom_range(7) == 0);
      n_sel       = 2'($urandom_range(3));
      guess_valid = ($urandom_range(1) == 0);
      guess_hit   = ($urandom_range(2) != 0);
      m_step(start, int'(n_sel), guess_valid, guess_hit);
      @(negedge clk);
      chk($sformatf("rand%0d", c), act_word(), m_word());
    end
    idle_cycles(1);

`ifdef TURN_TIMEOUT_EN
    // Timeout every TMO_CYC idle cycles; a guess on the timeout cycle wins
    sync_reset();
    start_game(2);
    idle_cycles(TMO_CYC - 1);
    chk("tmo_before", act_word(), mk_word(0, 2, 0, 0, 0, 0, 0, 0));
    idle_cycles(1);
    chk("tmo_first", act_word(), mk_word(1, 2, 0, 0, 0, 0, 0, 0));
    idle_cycles(TMO_CYC);
    chk("tmo_second", act_word(), mk_word(2, 2, 0, 0, 0, 0, 0, 0));
    idle_cycles(TMO_CYC - 1);
    pulse_guess(0);
    chk("tmo_vs_guess", act_word(), mk_word(3, 2, 0, 0, 0, 0, 0, 0));
    idle_cycles(TMO_CYC - 1);
    chk("tmo_cleared", act_word(), mk_word(3, 2, 0, 0, 0, 0, 0, 0));
    idle_cycles(1);
    chk("tmo_wrap", act_word(), mk_word(0, 2, 0, 0, 0, 0, 0, 0));
`else
    // Without the timeout feature, a long idle stretch never moves T
    sync_reset();
    start_game(1);
    idle_cycles(200);
    chk("no_tmo", act_word(), mk_word(0, 1, 0, 0, 0, 0, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends on its own
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/turn_score_ctrl.md
Name: turn_score_ctrl

Overview:
- Game-state stage directly upstream of the lower-display player-count multiplexer.
- Tracks the active turn and the per-player progress counts for 2-4 players.
- Produces the turn index T, the player-count code N and the four 5-bit counts that the multiplexer selects from.
- Also reports the winner and the end of the game to the top-level display/FSM.

Parameters:
- WIN_CNT, 24: progress count at which a player wins; range 1..31.
- TIMEOUT_CYC, 50_000_000: idle cycles before a turn is forfeited; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new game.
- n_sel  in  2  player-count code sampled at start: 00=2, 01=3, 10=4 players; 11 is treated as 10.
- guess_valid  in  1  one-cycle pulse; a tile guess has been resolved.
- guess_hit  in  1  qualifies guess_valid: 1=correct tile, 0=miss.
- T  out  2  index of the active player, 0-based.
- N  out  2  latched player-count code; never 11.
- p1_cnt, p2_cnt, p3_cnt, p4_cnt  out  5 each  per-player progress counts.
- game_over  out  1  high in DONE.
- winner  out  2  index of the winning player; valid while game_over=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, T=0, N=00, all counts=0, game_over=0, winner=0.
  - Reset may occur in any state, mid-game included; play resumes only on a new start.
- States: IDLE, PLAY, DONE.
- IDLE:
  - start=1 -> PLAY at the next edge; N<=clamped n_sel, T<=0, all counts<=0.
  - guess_valid is ignored.
- PLAY, registered update, visible one cycle after the guess_valid edge:
  - guess_valid & guess_hit: count[T]<=count[T]+1; T unchanged, so the player keeps the turn.
  - guess_valid & !guess_hit: T advances to the next player; counts unchanged.
  - If a hit makes count[T]+1==WIN_CNT: same edge count[T]<=WIN_CNT, state<=DONE, game_over<=1, winner<=T, T holds.
- Turn wrap: T wraps from the last player back to 0 (2 players: 1->0; 3: 2->0; 4: 3->0). T never exceeds N+1.
- Counts of unused players stay 0 for the whole game.
- Counts never exceed WIN_CNT; no 5-bit overflow is possible.
- start during PLAY is ignored; n_sel changes mid-game are ignored.
- DONE:
  - Outputs hold; guess_valid is ignored.
  - start=1 -> PLAY with a fresh init, identical to the IDLE->PLAY transition.
- Simultaneous start and guess_valid:
  - In IDLE/DONE, start wins.
  - In PLAY, start is ignored and the guess is processed.
- No combinational paths from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro TURN_TIMEOUT_EN.
- Defined:
  - A 26-bit idle counter runs in PLAY.
  - The counter clears on guess_valid, on the IDLE->PLAY transition, and on any T change.
  - On reaching TIMEOUT_CYC-1, T advances as on a miss and the counter clears.
  - A timeout coinciding with guess_valid is overridden: the guess is processed and the timeout is discarded.
  - Counter is held at 0 outside PLAY.
- Not defined: no counter is present; T changes only on a miss.

Test Plan:
- Reset, then start with n_sel=01 -> N=01, T=0, all counts=0; a miss pulse moves T 0->1->2->0 over three misses.
- n_sel=00, three hits then a miss -> p1_cnt=3, T=1; p2_cnt..p4_cnt stay 0.
- n_sel=11 -> N=10; four misses cycle T 0,1,2,3,0.
- WIN_CNT=4, n_sel=10, four hits by player 0 -> p1_cnt=4, game_over=1, winner=0. Further guesses leave all outputs unchanged. A new start clears counts and returns to PLAY.
- Mid-game rst_n low for a partial cycle -> outputs return to reset values immediately, without waiting for a clock edge. guess_valid after release is ignored until start.
- With TURN_TIMEOUT_EN, TIMEOUT_CYC=10:
  - No guesses -> T advances every 10 cycles.
  - guess_valid on the timeout cycle -> guess applied, no extra advance.
